// File: rtl/combo_tracker_pkg.sv
// Shared definitions for combo_tracker: judgement codes, field width and
// the BCD converter state encoding.
package combo_tracker_pkg;

    localparam int JW = 3;

    localparam logic [JW-1:0] JUDGE_NONE = 3'd0;
    localparam logic [JW-1:0] JUDGE_LOST = 3'd1;
    localparam logic [JW-1:0] JUDGE_FAR  = 3'd2;
    localparam logic [JW-1:0] JUDGE_PURE = 3'd3;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/combo_bcd_conv.sv
// Double-dabble binary-to-BCD converter, one shift per cycle. Start loads Bin;
// Done is high during the cycle of the final (CW-th) shift.
module combo_bcd_conv #(
    parameter int CW     = 16,
    parameter int DIGITS = 5
) (
    input  logic                OriginalClk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [CW-1:0]       Bin,
    output logic [4*DIGITS-1:0] Digits,
    output logic                Done
);

    localparam int RW = 4*DIGITS + CW;
    localparam int KW = $clog2(CW + 1);

    logic [RW-1:0] sr;
    logic [RW-1:0] sr_adj;
    logic [KW-1:0] left;

    // Adjust every BCD digit >= 5 before the shift so it carries correctly.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[CW+4*d +: 4] >= 4'd5) begin
                sr_adj[CW+4*d +: 4] = sr[CW+4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            sr   <= '0;
            left <= '0;
        end else if (Start) begin
            sr   <= {{(4*DIGITS){1'b0}}, Bin};
            left <= KW'(CW);
        end else if (left != '0) begin
            sr   <= {sr_adj[RW-2:0], 1'b0};
            left <= left - KW'(1);
        end
    end

    assign Digits = sr[RW-1 -: 4*DIGITS];
    assign Done   = (left == KW'(1));

endmodule

// File: rtl/combo_tracker.sv
// Per-song combo / judgement tracker with an optional BCD view of Combo,
// built only when COMBO_BCD_EN is defined.
module combo_tracker
    import combo_tracker_pkg::*;
#(
    parameter int TRACKS = 6,
    parameter int CW     = 16,
    parameter int DIGITS = 5
) (
    input  logic                 OriginalClk,
    input  logic                 Reset,
    input  logic                 Clear,
    input  logic [JW*TRACKS-1:0] Msg,
    output logic [CW-1:0]        Combo,
    output logic [CW-1:0]        MaxCombo,
    output logic [CW-1:0]        PureCount,
    output logic [CW-1:0]        FarCount,
    output logic [CW-1:0]        LostCount,
    output logic [4*DIGITS-1:0]  ComboDigits,
    output logic                 DigitsValid
);

    localparam int NW = $clog2(TRACKS + 1);
    localparam int SW = CW + NW;
    localparam logic [CW-1:0] CMAX = '1;

    logic [NW-1:0] n_pure, n_far, n_lost, n_hit;
    logic [CW-1:0] combo_next, max_next;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [NW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(CMAX)) ? CMAX : s[CW-1:0];
    endfunction

    // Codes 4..7 fall into the default arm and count as lost.
    always_comb begin
        n_pure = '0;
        n_far  = '0;
        n_lost = '0;
        for (int i = 0; i < TRACKS; i++) begin
            case (Msg[JW*i +: JW])
                JUDGE_NONE: ;
                JUDGE_PURE: n_pure = n_pure + NW'(1);
                JUDGE_FAR:  n_far  = n_far + NW'(1);
                default:    n_lost = n_lost + NW'(1);
            endcase
        end
    end

    always_comb begin
        n_hit      = n_pure + n_far;
        combo_next = (n_lost != '0) ? '0 : sat_add(Combo, n_hit);
        max_next   = (combo_next > MaxCombo) ? combo_next : MaxCombo;
    end

    always_ff @(posedge OriginalClk) begin
        if (Reset || Clear) begin
            Combo     <= '0;
            MaxCombo  <= '0;
            PureCount <= '0;
            FarCount  <= '0;
            LostCount <= '0;
        end else begin
            Combo     <= combo_next;
            MaxCombo  <= max_next;
            PureCount <= sat_add(PureCount, n_pure);
            FarCount  <= sat_add(FarCount, n_far);
            LostCount <= sat_add(LostCount, n_lost);
        end
    end

`ifdef COMBO_BCD_EN
    conv_state_t          conv_state, conv_state_next;
    logic                 dirty;
    logic                 combo_change;
    logic                 conv_start;
    logic                 conv_done;
    logic [4*DIGITS-1:0]  conv_digits;

    assign combo_change = (combo_next != Combo);

    always_comb begin
        conv_state_next = conv_state;
        conv_start      = 1'b0;
        case (conv_state)
            CONV_IDLE: begin
                if (dirty) begin
                    conv_start      = 1'b1;
                    conv_state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: if (conv_done) conv_state_next = CONV_DONE;
            CONV_DONE:  conv_state_next = CONV_IDLE;
            default:    conv_state_next = CONV_IDLE;
        endcase
    end

    // A change on the same edge as a snapshot or a DONE write keeps the
    // digits marked stale so IDLE starts another pass.
    always_ff @(posedge OriginalClk) begin
        if (Reset || Clear) begin
            conv_state  <= CONV_IDLE;
            dirty       <= 1'b0;
            ComboDigits <= '0;
            DigitsValid <= 1'b1;
        end else begin
            conv_state <= conv_state_next;
            dirty      <= combo_change | (dirty & ~conv_start);
            if (conv_start) begin
                DigitsValid <= 1'b0;
            end
            if (conv_state == CONV_DONE) begin
                ComboDigits <= conv_digits;
                DigitsValid <= ~dirty & ~combo_change;
            end
        end
    end

    combo_bcd_conv #(
        .CW     (CW),
        .DIGITS (DIGITS)
    ) u_conv (
        .OriginalClk (OriginalClk),
        .Reset       (Reset || Clear),
        .Start       (conv_start),
        .Bin         (Combo),
        .Digits      (conv_digits),
        .Done        (conv_done)
    );
`else
    assign ComboDigits = '0;
    assign DigitsValid = 1'b0;
`endif

endmodule

// File: tb/tb_combo_tracker.sv
// Self-checking bench for combo_tracker: reference model feeding an expected
// queue, directed scenarios, random traffic and a CW=4 saturation instance.
module tb_combo_tracker;

    localparam int CW     = 16;
    localparam int DIGITS = 5;
    localparam int MAXV   = 65535;
`ifdef COMBO_BCD_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [17:0] msg = '0;
    logic [CW-1:0] combo, max_combo, pure_cnt, far_cnt, lost_cnt;
    logic [19:0] digits;
    logic        dvalid;

    logic        rst4 = 1'b1;
    logic        clr4 = 1'b0;
    logic [17:0] msg4 = '0;
    logic [3:0]  combo4, max4, pure4, far4, lost4;
    logic [7:0]  digits4;
    logic        dvalid4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [79:0] exp_q[$];
    logic [79:0] exp_v;
    wire  [79:0] obs_v = {combo, max_combo, pure_cnt, far_cnt, lost_cnt};

    int m_combo, m_max, m_p, m_f, m_l;

    localparam logic [17:0] ALL_PURE = {6{3'd3}};
    localparam logic [17:0] ONE_PURE = 18'o000003;

    always #5 clk = ~clk;

    combo_tracker dut (
        .OriginalClk (clk),
        .Reset       (rst),
        .Clear       (clr),
        .Msg         (msg),
        .Combo       (combo),
        .MaxCombo    (max_combo),
        .PureCount   (pure_cnt),
        .FarCount    (far_cnt),
        .LostCount   (lost_cnt),
        .ComboDigits (digits),
        .DigitsValid (dvalid)
    );

    combo_tracker #(.TRACKS(6), .CW(4), .DIGITS(2)) dut4 (
        .OriginalClk (clk),
        .Reset       (rst4),
        .Clear       (clr4),
        .Msg         (msg4),
        .Combo       (combo4),
        .MaxCombo    (max4),
        .PureCount   (pure4),
        .FarCount    (far4),
        .LostCount   (lost4),
        .ComboDigits (digits4),
        .DigitsValid (dvalid4)
    );

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_push(input logic [17:0] m, input bit zero);
        int p, f, l;
        logic [2:0] c;
        p = 0; f = 0; l = 0;
        if (zero) begin
            m_combo = 0; m_max = 0; m_p = 0; m_f = 0; m_l = 0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                c = m[3*i +: 3];
                if (c == 3'd3) p++;
                else if (c == 3'd2) f++;
                else if (c != 3'd0) l++;
            end
            m_p = sat(m_p + p);
            m_f = sat(m_f + f);
            m_l = sat(m_l + l);
            m_combo = (l > 0) ? 0 : sat(m_combo + p + f);
            if (m_combo > m_max) m_max = m_combo;
        end
        exp_q.push_back({16'(m_combo), 16'(m_max), 16'(m_p), 16'(m_f), 16'(m_l)});
    endtask

    task automatic step(input logic [17:0] m, input bit c, input bit r);
        msg = m;
        clr = c;
        rst = r;
        model_push(m, c || r);
        @(posedge clk);
        #1;
        msg = '0;
        clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step('0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL reset_counters: got %h expected %h", obs_v, exp_v);
        end
        n_tests++;
        if (digits !== 20'h0 || dvalid !== BCD_EN) begin
            n_fail++; $display("FAIL reset_digits: got %h/%b expected 0/%b", digits, dvalid, BCD_EN);
        end
    endtask

    task automatic test_multi_hit_lost();
        step({3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3}, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (obs_v !== exp_v || combo !== 16'd6 || pure_cnt !== 16'd3 || far_cnt !== 16'd3) begin
            n_fail++; $display("FAIL multi_hit: got %h expected %h", obs_v, exp_v);
        end
        step({3'd0, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3}, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (obs_v !== exp_v || combo !== 16'd0 || max_combo !== 16'd6 ||
            pure_cnt !== 16'd7 || lost_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lost_breaks: got %h expected %h", obs_v, exp_v);
        end
    endtask

    task automatic test_bcd_latency();
        bit   ev;
        logic [19:0] ed;
        step('0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        step(ONE_PURE, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (obs_v !== exp_v || dvalid !== BCD_EN) begin
            n_fail++; $display("FAIL bcd_first_edge: got %h/%b expected %h/%b", obs_v, dvalid, exp_v, BCD_EN);
        end
        for (int j = 1; j <= CW + 2; j++) begin
            step('0, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            ev = BCD_EN && (j == CW + 2);
            ed = ev ? to_bcd(1) : 20'h0;
            n_tests++;
            if (obs_v !== exp_v || dvalid !== ev || digits !== ed) begin
                n_fail++;
                $display("FAIL bcd_latency edge %0d: got %h/%h/%b expected %h/%h/%b",
                         j, obs_v, digits, dvalid, exp_v, ed, ev);
            end
        end
    endtask

    task automatic test_mid_conversion();
        bit   ev;
        logic [19:0] ed;
        step('0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        step(ONE_PURE, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int j = 1; j <= 2*CW + 5; j++) begin
            step((j == 3) ? ONE_PURE : 18'h0, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            ev = BCD_EN && (j >= 2*CW + 4);
            n_tests++;
            if (obs_v !== exp_v || dvalid !== ev) begin
                n_fail++;
                $display("FAIL mid_conv edge %0d: got %h/%b expected %h/%b", j, obs_v, dvalid, exp_v, ev);
            end
            if (j == CW + 2 || j >= 2*CW + 4) begin
                ed = !BCD_EN ? 20'h0 : (j == CW + 2) ? to_bcd(1) : to_bcd(2);
                n_tests++;
                if (digits !== ed) begin
                    n_fail++; $display("FAIL mid_conv_digits edge %0d: got %h expected %h", j, digits, ed);
                end
            end
        end
    endtask

    task automatic test_illegal_clear();
        step('0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        step(18'o000005, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (obs_v !== exp_v || combo !== 16'd0 || lost_cnt !== 16'd1) begin
            n_fail++; $display("FAIL illegal_code: got %h expected %h", obs_v, exp_v);
        end
        step(ALL_PURE, 1'b1, 1'b0);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (obs_v !== exp_v || obs_v !== 80'h0 || digits !== 20'h0 || dvalid !== BCD_EN) begin
            n_fail++; $display("FAIL clear_override: got %h/%h/%b expected 0/0/%b", obs_v, digits, dvalid, BCD_EN);
        end
    endtask

    task automatic test_reset_abort();
        step('0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        step(ONE_PURE, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int j = 0; j < 3; j++) begin
            step('0, 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        for (int j = 0; j <= CW + 3; j++) begin
            step('0, 1'b0, j == 0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs_v !== exp_v || digits !== 20'h0 || dvalid !== BCD_EN) begin
                n_fail++;
                $display("FAIL reset_abort edge %0d: got %h/%h/%b expected %h/0/%b", j, obs_v, digits, dvalid, exp_v, BCD_EN);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] m;
        int r;
        step('0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        for (int n = 0; n < 300 + 2*CW + 6; n++) begin
            m = '0;
            if (n < 300) begin
                for (int i = 0; i < 6; i++) begin
                    r = $urandom_range(0, 99);
                    m[3*i +: 3] = (r < 40) ? 3'd0 : (r < 70) ? 3'd3 : (r < 97) ? 3'd2 :
                                  (r < 98) ? 3'd1 : 3'($urandom_range(4, 7));
                end
            end
            step(m, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL random cycle %0d: got %h expected %h", n, obs_v, exp_v);
            end
        end
        n_tests++;
        if (digits !== (BCD_EN ? to_bcd(m_combo) : 20'h0) || dvalid !== BCD_EN) begin
            n_fail++;
            $display("FAIL random_digits: got %h/%b expected %h/%b", digits, dvalid,
                     BCD_EN ? to_bcd(m_combo) : 20'h0, BCD_EN);
        end
    endtask

    task automatic test_saturation();
        int e;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            msg4 = ALL_PURE;
            @(posedge clk); #1;
            e = (6*c > 15) ? 15 : 6*c;
            n_tests++;
            if (combo4 !== 4'(e) || max4 !== 4'(e) || pure4 !== 4'(e) || lost4 !== 4'd0) begin
                n_fail++;
                $display("FAIL saturation cycle %0d: got %0d/%0d/%0d expected %0d", c, combo4, max4, pure4, e);
            end
        end
        msg4 = '0;
        for (int i = 0; i < 40; i++) begin
            if (BCD_EN && dvalid4 === 1'b1) break;
            @(posedge clk); #1;
        end
        n_tests++;
        if (digits4 !== (BCD_EN ? 8'h15 : 8'h00) || dvalid4 !== BCD_EN) begin
            n_fail++; $display("FAIL saturation_digits: got %h/%b expected %h/%b", digits4, dvalid4,
                               BCD_EN ? 8'h15 : 8'h00, BCD_EN);
        end
    endtask

    initial begin
        test_reset();
        test_multi_hit_lost();
        test_bcd_latency();
        test_mid_conversion();
        test_illegal_clear();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
